// File: rtl/fmap_stream_gen_if.sv
// Stream bus carrying feature-map beats from the generator to a downstream consumer.
interface fmap_stream_gen_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ROW_W      = 5,
    parameter int unsigned COL_W      = 5,
    parameter int unsigned DEP_W      = 3
);
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_ready;
    logic                  m_last;
    logic                  m_win;
    logic [ROW_W-1:0]      row_idx;
    logic [COL_W-1:0]      col_idx;
    logic [DEP_W-1:0]      dep_idx;

    modport master (
        output m_data, m_valid, m_last, m_win, row_idx, col_idx, dep_idx,
        input  m_ready
    );

    modport slave (
        input  m_data, m_valid, m_last, m_win, row_idx, col_idx, dep_idx,
        output m_ready
    );
endinterface

// File: rtl/fmap_stream_gen.sv
// Feature-map stream generator: walks a ROWS x COLS x DEPTH frame (depth innermost),
// emits one beat per pixel channel with a selectable data pattern, and flags beats
// that complete a KERNEL_SIZE window placed on a STRIDE grid.
module fmap_stream_gen #(
    parameter int unsigned ROWS        = 20,
    parameter int unsigned COLS        = 20,
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned KERNEL_SIZE = 3,
    parameter int unsigned STRIDE      = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic [1:0]        i_mode,
    input  logic [15:0]       i_cfg_value,
    fmap_stream_gen_if.master m_if,
    output logic              o_busy,
    output logic              o_done,
    output logic [31:0]       o_win_count
);
    localparam int unsigned ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned COL_W  = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int unsigned DEP_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned KS_MAX = (KERNEL_SIZE > STRIDE) ? KERNEL_SIZE : STRIDE;
    localparam int unsigned PH_W   = $clog2(KS_MAX) + 1;

    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(COLS - 1);
    localparam logic [DEP_W-1:0] DEP_LAST  = DEP_W'(DEPTH - 1);
    // Phase counters count down to the next window-aligned row/column; 0 means aligned.
    localparam logic [PH_W-1:0]  PH_INIT   = PH_W'(KERNEL_SIZE - 1);
    localparam logic [PH_W-1:0]  PH_RELOAD = PH_W'(STRIDE - 1);

    typedef enum logic [1:0] {StIdle, StStream, StDone} state_e;

    state_e                r_state;
    state_e                w_state_next;

    logic [1:0]            r_mode;
    logic [15:0]           r_cfg;
    logic [15:0]           r_lfsr;
    logic [DATA_WIDTH-1:0] r_lin;
    logic [ROW_W-1:0]      r_row;
    logic [COL_W-1:0]      r_col;
    logic [DEP_W-1:0]      r_dep;
    logic [PH_W-1:0]       r_row_ph;
    logic [PH_W-1:0]       r_col_ph;
    logic [31:0]           r_win_count;

    logic                  w_valid;
    logic                  w_fire;
    logic                  w_last;
    logic                  w_win;
    logic [15:0]           w_lfsr_next;
    logic [PH_W-1:0]       w_row_ph_next;
    logic [PH_W-1:0]       w_col_ph_next;
    logic [DATA_WIDTH-1:0] w_data;

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and status outputs.
    always_comb begin
        w_state_next = r_state;
        o_busy       = 1'b0;
        o_done       = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (i_start) begin
                    w_state_next = StStream;
                end
            end
            StStream: begin
                o_busy = 1'b1;
                if (i_abort || (w_fire && w_last)) begin
                    w_state_next = StDone;
                end
            end
            StDone: begin
                o_done       = 1'b1;
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // Beat qualifiers, pattern selection and phase/LFSR step values.
    always_comb begin
        w_valid       = (r_state == StStream);
        w_fire        = w_valid && m_if.m_ready;
        w_last        = w_valid && (r_row == ROW_LAST) && (r_col == COL_LAST)
                        && (r_dep == DEP_LAST);
        w_win         = w_valid && (r_dep == DEP_LAST) && (r_row_ph == '0)
                        && (r_col_ph == '0);
        // Fibonacci taps 16,14,13,11 -> bit indices 15,13,12,10.
        w_lfsr_next   = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
        w_row_ph_next = (r_row_ph == '0) ? PH_RELOAD : r_row_ph - PH_W'(1);
        w_col_ph_next = (r_col_ph == '0) ? PH_RELOAD : r_col_ph - PH_W'(1);
        w_data        = r_lin;
        unique case (r_mode)
            2'd1:    w_data = DATA_WIDTH'(r_cfg);
            2'd2:    w_data = DATA_WIDTH'(r_lfsr);
            default: w_data = r_lin;
        endcase
    end

    // Drive the stream bus; data is forced to zero whenever no beat is offered.
    always_comb begin
        m_if.m_valid = w_valid;
        m_if.m_data  = w_valid ? w_data : '0;
        m_if.m_last  = w_last;
        m_if.m_win   = w_win;
        m_if.row_idx = r_row;
        m_if.col_idx = r_col;
        m_if.dep_idx = r_dep;
        o_win_count  = r_win_count;
    end

    // Frame datapath: config capture on start, coordinate walk and pattern advance per beat.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mode      <= 2'd0;
            r_cfg       <= 16'd0;
            r_lfsr      <= 16'h0001;
            r_lin       <= '0;
            r_row       <= '0;
            r_col       <= '0;
            r_dep       <= '0;
            r_row_ph    <= PH_INIT;
            r_col_ph    <= PH_INIT;
            r_win_count <= 32'd0;
        end else if ((r_state == StIdle) && i_start) begin
            r_mode      <= i_mode;
            r_cfg       <= i_cfg_value;
            r_lfsr      <= (i_cfg_value == 16'd0) ? 16'h0001 : i_cfg_value;
            r_lin       <= '0;
            r_row       <= '0;
            r_col       <= '0;
            r_dep       <= '0;
            r_row_ph    <= PH_INIT;
            r_col_ph    <= PH_INIT;
            r_win_count <= 32'd0;
        end else if (w_fire) begin
            r_lfsr <= w_lfsr_next;
            r_lin  <= r_lin + DATA_WIDTH'(1);
            if (w_win) begin
                r_win_count <= r_win_count + 32'd1;
            end
            // A beat accepted alongside abort still counts; the walk then parks at zero.
            if (w_last || i_abort) begin
                r_row    <= '0;
                r_col    <= '0;
                r_dep    <= '0;
                r_row_ph <= PH_INIT;
                r_col_ph <= PH_INIT;
            end else if (r_dep != DEP_LAST) begin
                r_dep <= r_dep + DEP_W'(1);
            end else begin
                r_dep <= '0;
                if (r_col != COL_LAST) begin
                    r_col    <= r_col + COL_W'(1);
                    r_col_ph <= w_col_ph_next;
                end else begin
                    r_col    <= '0;
                    r_col_ph <= PH_INIT;
                    r_row    <= r_row + ROW_W'(1);
                    r_row_ph <= w_row_ph_next;
                end
            end
        end else if (w_valid && i_abort) begin
            r_row    <= '0;
            r_col    <= '0;
            r_dep    <= '0;
            r_row_ph <= PH_INIT;
            r_col_ph <= PH_INIT;
        end
    end
endmodule

// File: doc/fmap_stream_gen.md
FMAP_STREAM_GEN -- requirements
Module: fmap_stream_gen

Interface
REQ-001 SHALL have parameter ROWS, default 20, feature-map rows (>= KERNEL_SIZE).
REQ-002 SHALL have parameter COLS, default 20, feature-map columns (>= KERNEL_SIZE).
REQ-003 SHALL have parameter DEPTH, default 8, channels per pixel (>= 1).
REQ-004 SHALL have parameter DATA_WIDTH, default 16, beat data width (1..32).
REQ-005 SHALL have parameter KERNEL_SIZE, default 3, window edge length.
REQ-006 SHALL have parameter STRIDE, default 2, window step (>= 1).
REQ-007 SHALL have port clk  input  1  sole clock; all logic rising-edge.
REQ-008 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-009 SHALL have port start  input  1  single-cycle frame request.
REQ-010 SHALL have port abort  input  1  terminate current frame.
REQ-011 SHALL have port mode  input  2  pattern: 0 incrementing, 1 constant, 2 LFSR, 3 treated as 0.
REQ-012 SHALL have port cfg_value  input  16  constant value (mode 1) or LFSR seed (mode 2).
REQ-013 SHALL have port m_data  output  DATA_WIDTH  beat payload.
REQ-014 SHALL have port m_valid  output  1  beat valid.
REQ-015 SHALL have port m_ready  input  1  downstream accept.
REQ-016 SHALL have port m_last  output  1  final beat of frame.
REQ-017 SHALL have port m_win  output  1  beat completes a strided window.
REQ-018 SHALL have ports row_idx/col_idx/dep_idx  output  clog2 widths  coordinates of current beat.
REQ-019 SHALL have port busy  output  1  FSM in STREAM.
REQ-020 SHALL have port done  output  1  one-cycle pulse after last accepted beat or abort.
REQ-021 SHALL have port win_count  output  32  windows flagged in last frame, held until next start.

Function
REQ-022 FSM SHALL have states IDLE, STREAM, DONE; IDLE->STREAM on start; STREAM->DONE on accepted m_last beat or abort; DONE->IDLE unconditionally next cycle.
REQ-023 mode and cfg_value SHALL be sampled on the start cycle only; later changes ignored until next frame.
REQ-024 Beat order SHALL be dep_idx innermost, then col_idx, then row_idx; ROWS*COLS*DEPTH beats per frame.
REQ-025 m_valid SHALL rise the cycle after start is accepted; a beat transfers when m_valid && m_ready.
REQ-026 While m_valid && !m_ready, m_data, m_last, m_win and indices SHALL hold stable.
REQ-027 Mode 0: m_data = linear beat index mod 2^DATA_WIDTH, first beat 0.
REQ-028 Mode 1: m_data = cfg_value truncated/zero-extended to DATA_WIDTH on every beat.
REQ-029 Mode 2: 16-bit Fibonacci LFSR, taps 16,14,13,11, loaded with seed (0 replaced by 16'h0001), advanced once per accepted beat; m_data = LFSR truncated/zero-extended.
REQ-030 m_last SHALL assert only on beat (ROWS-1, COLS-1, DEPTH-1).
REQ-031 m_win SHALL assert iff dep_idx==DEPTH-1, row_idx>=K-1, col_idx>=K-1, (row_idx-K+1)%STRIDE==0, (col_idx-K+1)%STRIDE==0.
REQ-032 win_count SHALL clear on start and increment on each accepted beat with m_win.
REQ-033 start while busy or in DONE SHALL be ignored.
REQ-034 abort in STREAM SHALL drop m_valid next cycle, skip remaining beats, pulse done; win_count holds partial total; abort in IDLE ignored.
REQ-035 Simultaneous abort and accepted beat SHALL count that beat, then terminate.

Reset
REQ-036 On rst: state IDLE; m_valid, m_last, m_win, busy, done = 0; m_data, indices, win_count = 0; LFSR = 16'h0001.
REQ-037 rst mid-frame SHALL abandon the frame without a done pulse; rst dominates start and abort.

Verification
REQ-038 Defaults, mode 0, m_ready=1 -> 3200 beats back-to-back, m_data 0..3199, m_last on beat 3199, 81 m_win beats, win_count=81, done one cycle after last.
REQ-039 Mode 1, cfg_value=16'hA5A5, m_ready toggling 1/0 -> every beat 16'hA5A5, outputs stable during stalls, 3200 transfers.
REQ-040 Mode 2, cfg_value=0 -> first beat 16'h0001, sequence matches reference LFSR model with seed 1.
REQ-041 Abort after 100 accepted beats -> m_valid low next cycle, done pulses, win_count equals flags in first 100 beats (0).
REQ-042 start asserted during STREAM -> ignored, frame completes with 3200 beats.
REQ-043 rst at beat 500 -> all outputs zero next cycle, no done; new start yields full frame from beat 0.
